data_sram_responder: RTL and testbench

Slave end of the CPU's SRAM-like data interface: accepts data requests from the EX stage (req/addr_ok handshake) and returns in-order responses (data_ok/rdata) that the MEM stage consumes. It holds a word-addressed memory with byte-strobe writes, tracks up to DEPTH outstanding requests, and gives each one a fixed, programmable response latency. It is used as the data-side memory in the pipeline's simulation SoC, and as a stress responder via the `addr_stall` input.

---
 rtl/data_sram_responder.sv | 96 +++++++++
 tb/tb_data_sram_responder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Data-side SRAM slave: byte-strobed word memory with an in-order response queue, data_ok LATENCY cycles after accept.
// addr_ok drops while DEPTH requests are outstanding or addr_stall is set; responses cannot be refused.
module data_sram_responder #(
    parameter int MEM_AW  = 10,
    parameter int DEPTH   = 2,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    input  logic        addr_stall
);
    localparam int         QN       = 4;
    localparam logic [1:0] PTR_LAST = 2'(DEPTH - 1);
    localparam logic [2:0] CNT_MAX  = 3'(DEPTH);
    localparam logic [3:0] TMR_INIT = 4'(LATENCY - 1);

    logic [31:0] r_mem   [2**MEM_AW];
    logic        r_is_wr [QN];
    logic [31:0] r_data  [QN];
    logic [3:0]  r_timer [QN];
    logic [1:0]  r_head;
    logic [1:0]  r_tail;
    logic [2:0]  r_count;

    logic [MEM_AW-1:0] w_idx;
    logic              w_accept;
    logic              w_pop;
    logic              w_unused;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_idx             = data_sram_addr[MEM_AW+1:2];
    assign data_sram_addr_ok = (r_count < CNT_MAX) && !addr_stall;
    assign w_accept          = data_sram_req && data_sram_addr_ok && !reset;
    assign w_pop             = (r_count != 3'd0) && (r_timer[r_head] == 4'd0);
    assign data_sram_data_ok = w_pop;
    assign data_sram_rdata   = (w_pop && !r_is_wr[r_head]) ? r_data[r_head] : 32'h0;
    // size is informational and the upper/lower address bits alias away
    assign w_unused          = ^{data_sram_size, data_sram_addr[31:MEM_AW+2], data_sram_addr[1:0]};

    always_ff @(posedge clk) begin
        if (w_accept && data_sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_count <= 3'd0;
            for (int i = 0; i < QN; i++) begin
                r_timer[i] <= 4'd0;
                r_is_wr[i] <= 1'b0;
                r_data[i]  <= 32'h0;
            end
        end else begin
            for (int i = 0; i < QN; i++) begin
                if (w_accept && (r_tail == 2'(i))) begin
                    r_timer[i] <= TMR_INIT;
                    r_is_wr[i] <= data_sram_wr;
                    // read data is captured now, so later writes never leak into it
                    r_data[i]  <= data_sram_wr ? 32'h0 : r_mem[w_idx];
                end else if (r_timer[i] != 4'd0) begin
                    r_timer[i] <= r_timer[i] - 4'd1;
                end
            end
            if (w_accept) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// Two responders (LATENCY 2 and 4, DEPTH 2) driven side by side against a queue-based reference model.
module tb_data_sram_responder;
    localparam int AW    = 10;
    localparam int NW    = 1 << AW;
    localparam int DEPTH = 2;
    localparam int LAT0  = 2;
    localparam int LAT1  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req     [2];
    logic        wr      [2];
    logic [1:0]  size    [2];
    logic [3:0]  wstrb   [2];
    logic [31:0] addr    [2];
    logic [31:0] wdata   [2];
    logic        stall   [2];
    logic        addr_ok [2];
    logic        data_ok [2];
    logic [31:0] rdata   [2];

    always #5 clk = ~clk;

    data_sram_responder #(.MEM_AW(AW), .DEPTH(DEPTH), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .reset(reset),
        .data_sram_req(req[0]), .data_sram_wr(wr[0]), .data_sram_size(size[0]),
        .data_sram_wstrb(wstrb[0]), .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
        .data_sram_addr_ok(addr_ok[0]), .data_sram_data_ok(data_ok[0]),
        .data_sram_rdata(rdata[0]), .addr_stall(stall[0])
    );

    data_sram_responder #(.MEM_AW(AW), .DEPTH(DEPTH), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .reset(reset),
        .data_sram_req(req[1]), .data_sram_wr(wr[1]), .data_sram_size(size[1]),
        .data_sram_wstrb(wstrb[1]), .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
        .data_sram_addr_ok(addr_ok[1]), .data_sram_data_ok(data_ok[1]),
        .data_sram_rdata(rdata[1]), .addr_stall(stall[1])
    );

    int checks   = 0;
    int failures = 0;

    // reference model: memory image plus a list of pending responses with their due cycle
    logic [31:0] mm   [2][NW];
    bit          mk   [2][NW];
    int          qn   [2];
    int          qdue [2][4];
    logic [31:0] qdat [2][4];
    bit          qkn  [2][4];
    bit          resp_now [2];
    int          lat  [2];
    int          edge_n;

    bit          acc_last [2];
    bit          obs_aok  [2];
    int          rcnt     [2];
    logic [31:0] log0 [$];

    logic        op_wr [2][8];
    logic [3:0]  op_st [2][8];
    logic [31:0] op_a  [2][8];
    logic [31:0] op_d  [2][8];
    int          nop   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic r, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] wd);
        req[d]   = r;
        wr[d]    = w;
        size[d]  = 2'd2;
        wstrb[d] = s;
        addr[d]  = a;
        wdata[d] = wd;
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic model_edge(input int d, input bit acc);
        int w;
        logic [31:0] old;
        bit kn;
        if (reset) begin
            qn[d] = 0;
        end else if (acc) begin
            w   = int'((addr[d] >> 2) % NW);
            old = mm[d][w];
            kn  = mk[d][w];
            if (wr[d]) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[d][b]) mm[d][w][8*b +: 8] = wdata[d][8*b +: 8];
                if (wstrb[d] == 4'hF) mk[d][w] = 1'b1;
            end
            if (qn[d] < 4) begin
                qdue[d][qn[d]] = edge_n + lat[d] - 1;
                qdat[d][qn[d]] = wr[d] ? 32'h0 : old;
                qkn[d][qn[d]]  = wr[d] || kn;
                qn[d]++;
            end
        end
    endtask

    task automatic model_out(input int d);
        logic exp_ok;
        exp_ok = (qn[d] > 0) && (qdue[d][0] == edge_n);
        chk($sformatf("data_ok[%0d]@%0d", d, edge_n), 32'(data_ok[d]), 32'(exp_ok));
        if (data_ok[d]) rcnt[d]++;
        if (d == 0 && data_ok[0]) log0.push_back(rdata[0]);
        if (exp_ok) begin
            if (qkn[d][0]) chk($sformatf("rdata[%0d]@%0d", d, edge_n), rdata[d], qdat[d][0]);
            for (int i = 0; i < 3; i++) begin
                qdue[d][i] = qdue[d][i+1];
                qdat[d][i] = qdat[d][i+1];
                qkn[d][i]  = qkn[d][i+1];
            end
            qn[d]--;
            resp_now[d] = 1'b1;
        end else begin
            chk($sformatf("rdata_idle[%0d]@%0d", d, edge_n), rdata[d], 32'h0);
            resp_now[d] = 1'b0;
        end
    endtask

    // one clock: check addr_ok before the edge, advance the model, check responses after it
    task automatic step();
        logic exp_aok [2];
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_aok[d]  = ((qn[d] + (resp_now[d] ? 1 : 0)) < DEPTH) && !stall[d];
            obs_aok[d]  = addr_ok[d];
            acc_last[d] = req[d] && addr_ok[d];
            chk($sformatf("addr_ok[%0d]@%0d", d, edge_n), 32'(addr_ok[d]), 32'(exp_aok[d]));
        end
        @(posedge clk);
        edge_n++;
        for (int d = 0; d < 2; d++) model_edge(d, req[d] && exp_aok[d] && !reset);
        #1;
        for (int d = 0; d < 2; d++) model_out(d);
    endtask

    task automatic clear_ops();
        nop[0] = 0;
        nop[1] = 0;
    endtask

    task automatic add_op(input int d, input logic w, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] wd);
        op_wr[d][nop[d]] = w;
        op_st[d][nop[d]] = s;
        op_a[d][nop[d]]  = a;
        op_d[d][nop[d]]  = wd;
        nop[d]++;
    endtask

    // hold req high on each DUT until its whole op list is accepted, then drain
    task automatic burst();
        int k [2];
        int c;
        k[0] = 0;
        k[1] = 0;
        c = 0;
        while ((k[0] < nop[0] || k[1] < nop[1]) && c < 100) begin
            for (int d = 0; d < 2; d++) begin
                if (k[d] < nop[d]) drive(d, 1'b1, op_wr[d][k[d]], op_st[d][k[d]], op_a[d][k[d]], op_d[d][k[d]]);
                else idle(d);
            end
            step();
            c++;
            for (int d = 0; d < 2; d++)
                if (k[d] < nop[d] && acc_last[d]) k[d]++;
        end
        idle(0);
        idle(1);
        chk("burst_accepted0", 32'(k[0]), 32'(nop[0]));
        chk("burst_accepted1", 32'(k[1]), 32'(nop[1]));
        repeat (8) step();
        clear_ops();
    endtask

    initial begin
        int n_low;
        lat[0] = LAT0;
        lat[1] = LAT1;
        reset  = 1'b1;
        for (int d = 0; d < 2; d++) begin
            idle(d);
            stall[d]    = 1'b0;
            qn[d]       = 0;
            resp_now[d] = 1'b0;
            rcnt[d]     = 0;
            for (int w = 0; w < NW; w++) mk[d][w] = 1'b0;
        end
        edge_n = 0;
        clear_ops();

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_data_ok", 32'(data_ok[d]), 32'd0);
            chk("reset_rdata", rdata[d], 32'h0);
            chk("reset_addr_ok", 32'(addr_ok[d]), 32'd1);
        end
        reset = 1'b0;

        // single round trip
        log0.delete();
        add_op(0, 1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF);
        add_op(0, 1'b0, 4'h0, 32'h0000_1000, 32'h0);
        burst();
        chk("rt_count", 32'(log0.size()), 32'd2);
        chk("rt_wr_resp", log0[0], 32'h0);
        chk("rt_rd_resp", log0[1], 32'hDEAD_BEEF);

        // byte strobes
        log0.delete();
        add_op(0, 1'b1, 4'hF, 32'h0000_2000, 32'h1122_3344);
        add_op(0, 1'b1, 4'b1000, 32'h0000_2000, 32'hAA00_0000);
        add_op(0, 1'b0, 4'h0, 32'h0000_2000, 32'h0);
        burst();
        chk("strobe_count", 32'(log0.size()), 32'd3);
        chk("strobe_rd", log0[2], 32'hAA22_3344);

        // back-to-back reads on both latencies
        for (int i = 0; i < 6; i++) begin
            add_op(0, 1'b1, 4'hF, 32'h3000 + 32'(4*i), 32'h100 + 32'(i));
            add_op(1, 1'b1, 4'hF, 32'h3000 + 32'(4*i), 32'h100 + 32'(i));
        end
        burst();
        log0.delete();
        rcnt[0] = 0;
        rcnt[1] = 0;
        for (int i = 0; i < 6; i++) begin
            add_op(0, 1'b0, 4'h0, 32'h3000 + 32'(4*i), 32'h0);
            add_op(1, 1'b0, 4'h0, 32'h3000 + 32'(4*i), 32'h0);
        end
        burst();
        chk("b2b_resp0", 32'(rcnt[0]), 32'd6);
        chk("b2b_resp1", 32'(rcnt[1]), 32'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("b2b_order%0d", i), log0[i], 32'h100 + 32'(i));

        // ordering and aliasing
        add_op(0, 1'b1, 4'hF, 32'h0000_4000, 32'h77);
        burst();
        log0.delete();
        add_op(0, 1'b0, 4'h0, 32'h0000_4000, 32'h0);
        add_op(0, 1'b1, 4'hF, 32'h0000_4000, 32'h5);
        add_op(0, 1'b0, 4'h0, 32'h0000_4000, 32'h0);
        add_op(0, 1'b0, 4'h0, 32'h0000_4000 + (32'd4 << AW), 32'h0);
        burst();
        chk("ord_old", log0[0], 32'h77);
        chk("ord_wr", log0[1], 32'h0);
        chk("ord_new", log0[2], 32'h5);
        chk("ord_alias", log0[3], 32'h5);

        // stall with two requests outstanding
        rcnt[0] = 0;
        drive(0, 1'b1, 1'b0, 4'h0, 32'h0000_4000, 32'h0);
        step();
        drive(0, 1'b1, 1'b0, 4'h0, 32'h0000_3004, 32'h0);
        step();
        stall[0] = 1'b1;
        drive(0, 1'b1, 1'b0, 4'h0, 32'h0000_3008, 32'h0);
        n_low = 0;
        repeat (5) begin
            step();
            if (!obs_aok[0]) n_low++;
        end
        stall[0] = 1'b0;
        idle(0);
        repeat (4) step();
        chk("stall_resp", 32'(rcnt[0]), 32'd2);
        chk("stall_addr_ok_low", 32'(n_low), 32'd5);

        // reset with requests outstanding; the accepted write must survive
        drive(0, 1'b1, 1'b0, 4'h0, 32'h0000_3000, 32'h0);
        drive(1, 1'b1, 1'b1, 4'hF, 32'h0000_6000, 32'hCAFE_0001);
        step();
        drive(0, 1'b1, 1'b0, 4'h0, 32'h0000_3004, 32'h0);
        drive(1, 1'b1, 1'b0, 4'h0, 32'h0000_3004, 32'h0);
        step();
        idle(0);
        idle(1);
        rcnt[0] = 0;
        rcnt[1] = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("post_reset_addr_ok0", 32'(obs_aok[0]), 32'd1);
        chk("post_reset_addr_ok1", 32'(obs_aok[1]), 32'd1);
        repeat (6) step();
        chk("post_reset_resp0", 32'(rcnt[0]), 32'd0);
        chk("post_reset_resp1", 32'(rcnt[1]), 32'd0);
        add_op(1, 1'b0, 4'h0, 32'h0000_6000, 32'h0);
        burst();

        // random traffic over a small aliased pool
        for (int i = 0; i < 8; i++) begin
            add_op(0, 1'b1, 4'hF, 32'h8000 + 32'(4*i), $urandom);
            add_op(1, 1'b1, 4'hF, 32'h8000 + 32'(4*i), $urandom);
        end
        burst();
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                drive(d, ($urandom % 4) != 0, $urandom_range(0, 1) == 1, 4'($urandom),
                      32'h8000 + ($urandom % 8) * 4 + ($urandom % 4) + (($urandom % 4) << (AW + 2)),
                      $urandom);
                stall[d] = ($urandom % 10) == 0;
            end
            step();
        end
        for (int d = 0; d < 2; d++) begin
            idle(d);
            stall[d] = 1'b0;
        end
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
